// File: rtl/ydemux1to4_buf_if.sv
// Stream bundle for the buffered 1-to-4 demultiplexer: one producer side, four consumer channels.
interface ydemux1to4_buf_if #(
  parameter int SIZE = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_data;
  logic [1:0]      sel;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [SIZE-1:0] out_data0;
  logic [SIZE-1:0] out_data1;
  logic [SIZE-1:0] out_data2;
  logic [SIZE-1:0] out_data3;

  // Environment side: drives the producer word and the consumer ready flags.
  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/ydemux1to4_buf.sv
// Buffered 1-to-4 stream demultiplexer: each channel has a one-word holding register,
// so a stalled consumer only blocks words addressed to it.
module ydemux1to4_buf #(
  parameter int SIZE = 2
) (
  input logic            clk,
  input logic            reset,
  ydemux1to4_buf_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  ch_state_t       state_p0  [4];
  ch_state_t       state_nxt [4];
  logic [SIZE-1:0] hold_p0   [4];
  logic [3:0]      load;
  logic            in_ready_c;
  logic            accept;

  // A full channel still accepts when its consumer drains in the same cycle.
  assign in_ready_c   = (state_p0[bus.sel] == EMPTY) || bus.out_ready[bus.sel];
  assign accept       = bus.in_valid && in_ready_c;
  assign bus.in_ready = in_ready_c;

  always_comb begin
    load = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      load[i] = accept && (bus.sel == 2'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state_p0[i];
      case (state_p0[i])
        EMPTY:   if (load[i]) state_nxt[i] = FULL;
        FULL:    if (bus.out_ready[i] && !load[i]) state_nxt[i] = EMPTY;
        default: state_nxt[i] = EMPTY;
      endcase
    end
  end

  // ---- stage p0: per-channel holding registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_p0[i] <= EMPTY;
        hold_p0[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_p0[i] <= state_nxt[i];
        if (load[i]) hold_p0[i] <= bus.in_data;
      end
    end
  end

  always_comb begin
    bus.out_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.out_valid[i] = (state_p0[i] == FULL);
    end
  end

  assign bus.out_data0 = hold_p0[0];
  assign bus.out_data1 = hold_p0[1];
  assign bus.out_data2 = hold_p0[2];
  assign bus.out_data3 = hold_p0[3];

endmodule

// File: tb/tb_ydemux1to4_buf.sv
// Directed and randomized checks of ydemux1to4_buf with SIZE = 4.
module tb_ydemux1to4_buf;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  ydemux1to4_buf_if #(.SIZE(4)) bus ();

  ydemux1to4_buf #(.SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] out_word(input int ch);
    case (ch)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.sel       = 2'd0;
    bus.out_ready = 4'b0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b, required 0000", bus.out_valid);
    end
    for (int ch = 0; ch < 4; ch++) begin
      n_cmp++;
      if (out_word(ch) !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_out_data%0d: got %h, required 0", ch, out_word(ch));
      end
    end
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready_sel%0d: got %b, required 1", s, bus.in_ready);
      end
    end
  endtask

  task automatic test_routing();
    logic [3:0] w [4];
    logic [3:0] ev;
    w[0] = 4'hA; w[1] = 4'h5; w[2] = 4'hC; w[3] = 4'h3;
    @(negedge clk);
    bus.out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[k];
      bus.sel      = 2'(k);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL route_in_ready%0d: got %b, required 1", k, bus.in_ready);
      end
      @(negedge clk);
      ev = 4'b0001 << k;
      n_cmp++;
      if (bus.out_valid !== ev) begin
        n_fail++;
        $display("FAIL route_out_valid%0d: got %b, required %b", k, bus.out_valid, ev);
      end
      n_cmp++;
      if (out_word(k) !== w[k]) begin
        n_fail++;
        $display("FAIL route_out_data%0d: got %h, required %h", k, out_word(k), w[k]);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL route_drained: got %b, required 0000", bus.out_valid);
    end
  endtask

  task automatic test_blocked();
    bus.out_ready = 4'b1110;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h9;
    bus.sel       = 2'd0;
    @(negedge clk);
    bus.in_data = 4'h6;
    bus.sel     = 2'd0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL blocked_in_ready: got %b, required 0", bus.in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_data0 !== 4'h9) begin
      n_fail++;
      $display("FAIL blocked_hold_data0: got %h, required 9", bus.out_data0);
    end
    n_cmp++;
    if (bus.out_valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL blocked_out_valid: got %b, required 0001", bus.out_valid);
    end
    // Redirect the stalled producer to an unblocked channel.
    bus.in_data = 4'h2;
    bus.sel     = 2'd1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL blocked_other_ready: got %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 4'b0011) begin
      n_fail++;
      $display("FAIL blocked_two_valid: got %b, required 0011", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data1 !== 4'h2 || bus.out_data0 !== 4'h9) begin
      n_fail++;
      $display("FAIL blocked_two_data: got d0=%h d1=%h, required d0=9 d1=2", bus.out_data0, bus.out_data1);
    end
    bus.out_ready = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL blocked_release: got %b, required 0000", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h1;
    bus.sel       = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 4'b0100 || bus.out_data2 !== 4'h1) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b d2=%h, required v=0100 d2=1", bus.out_valid, bus.out_data2);
    end
    bus.out_ready = 4'b0100;
    bus.in_data   = 4'h7;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_in_ready: got %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    n_cmp++;
    if (bus.out_valid !== 4'b0100 || bus.out_data2 !== 4'h7) begin
      n_fail++;
      $display("FAIL b2b_refill: got v=%b d2=%h, required v=0100 d2=7", bus.out_valid, bus.out_data2);
    end
    bus.out_ready = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_drain: got %b, required 0000", bus.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hA;
    bus.sel       = 2'd0;
    @(negedge clk);
    bus.in_data = 4'h5;
    bus.sel     = 2'd3;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 4'b1001) begin
      n_fail++;
      $display("FAIL midrst_setup: got %b, required 1001", bus.out_valid);
    end
    // An accept offered during reset must be dropped.
    reset        = 1'b1;
    bus.in_data  = 4'hE;
    bus.sel      = 2'd1;
    @(negedge clk);
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_valid: got %b, required 0000", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data0 !== 4'h0 || bus.out_data3 !== 4'h0 || bus.out_data1 !== 4'h0) begin
      n_fail++;
      $display("FAIL midrst_data: got d0=%h d1=%h d3=%h, required 0", bus.out_data0, bus.out_data1, bus.out_data3);
    end
    bus.out_ready = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_no_delivery: got %b, required 0000", bus.out_valid);
    end
    bus.out_ready = 4'b0000;
  endtask

  task automatic test_soak();
    logic [3:0] mq [4][$];
    logic       pend;
    logic [3:0] pdata;
    logic [1:0] psel;
    logic       exp_rdy;
    logic       exp_v;
    int         accepted;
    int         drained;
    pend = 1'b0; pdata = 4'h0; psel = 2'd0;
    accepted = 0; drained = 0;
    for (int c = 0; c < 520; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        exp_v = (mq[ch].size() != 0);
        n_cmp++;
        if (bus.out_valid[ch] !== exp_v) begin
          n_fail++;
          $display("FAIL soak_valid c%0d ch%0d: got %b, required %b", c, ch, bus.out_valid[ch], exp_v);
        end else if (exp_v) begin
          n_cmp++;
          if (out_word(ch) !== mq[ch][0]) begin
            n_fail++;
            $display("FAIL soak_data c%0d ch%0d: got %h, required %h", c, ch, out_word(ch), mq[ch][0]);
          end
        end
      end
      // The last 20 cycles only drain so every word must come out.
      if (c >= 500) begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
      end else begin
        if (!pend) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          pdata        = 4'($urandom);
          psel         = 2'($urandom);
        end
        bus.out_ready = 4'($urandom);
      end
      bus.in_data = pdata;
      bus.sel     = psel;
      #1;
      exp_rdy = (mq[psel].size() == 0) || bus.out_ready[psel];
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL soak_in_ready c%0d sel%0d: got %b, required %b", c, psel, bus.in_ready, exp_rdy);
      end
      @(posedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if (mq[ch].size() != 0 && bus.out_ready[ch]) begin
          void'(mq[ch].pop_front());
          drained++;
        end
      end
      if (bus.in_valid && exp_rdy) begin
        mq[psel].push_back(pdata);
        accepted++;
      end
      pend = bus.in_valid && !exp_rdy;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 4'b0000 || accepted != drained) begin
      n_fail++;
      $display("FAIL soak_final: got v=%b drained=%0d, required v=0000 drained=%0d", bus.out_valid, drained, accepted);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_routing();
    test_blocked();
    test_back_to_back();
    test_mid_reset();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
